mem_wb_bridge: RTL and testbench
================================

MEM_WB_BRIDGE -- requirements
Module: mem_wb_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of bus-cycle clocks to wait for wb_ack_i before aborting.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port cpu_req_i, input, 1 bit: CPU request, held until the edge where cpu_ready_o=1.
REQ-005 SHALL have port cpu_we_i, input, 1 bit: 1 = write, 0 = read.
REQ-006 SHALL have port cpu_sel_i, input, 4 bits: byte enables.
REQ-007 SHALL have port cpu_adr_i, input, 32 bits: byte address.
REQ-008 SHALL have port cpu_dat_i, input, 32 bits: write data.
REQ-009 SHALL have port cpu_dat_o, output, 32 bits: read data.
REQ-010 SHALL have port cpu_ready_o, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have Wishbone master ports wb_cyc_o, wb_stb_o, wb_we_o (1 bit each, outputs), wb_sel_o (4 bits, output), wb_adr_o (32 bits, output), wb_dat_o (32 bits, output), wb_dat_i (32 bits, input) and wb_ack_i (1 bit, input).
REQ-012 SHALL have port err_clr_i, input, 1 bit: clears err_o.
REQ-013 SHALL have port err_o, output, 1 bit: sticky bus-timeout flag.

Function
REQ-014 SHALL use FSM states IDLE, BUS and RESP; all outputs are registered.
REQ-015 IDLE, cpu_req_i=1, cpu_sel_i!=0: SHALL latch adr (with [1:0] forced to 0), sel, data and we, and go to BUS with wb_cyc_o=wb_stb_o=1 on the next cycle.
REQ-016 IDLE, cpu_req_i=1, cpu_sel_i=0: SHALL start no bus cycle, go to RESP, and return cpu_dat_o=0.
REQ-017 Writes are posted: cpu_ready_o SHALL be 1 in the first BUS cycle of a write, and the write then completes on the bus without CPU involvement.
REQ-018 While in BUS, cpu_req_i SHALL be ignored; a new request waits in IDLE until the posted write drains.
REQ-019 BUS, wb_ack_i=1: SHALL deassert cyc/stb on the next cycle; a read SHALL capture wb_dat_i into cpu_dat_o and go to RESP; a write SHALL go to IDLE.
REQ-020 RESP SHALL assert cpu_ready_o for exactly 1 cycle, ignore cpu_req_i, and go to IDLE.
REQ-021 Read latency SHALL be: req in cycle 0, stb in cycle 1, ack earliest in cycle 1, cpu_ready_o in cycle ack+1.
REQ-022 An 8-bit timeout counter (width ≥ clog2(TIMEOUT+1)) SHALL clear on BUS entry and increment each BUS cycle without ack.
REQ-023 Counter = TIMEOUT with no ack: SHALL drop cyc/stb and set err_o=1; a read SHALL go to RESP with cpu_dat_o=32'hDEADBEEF; a write SHALL go to IDLE.
REQ-024 Ack in the same cycle the counter reaches TIMEOUT: the ack SHALL win, with no error.
REQ-025 err_o SHALL stay set until err_clr_i=1; a timeout coincident with err_clr_i SHALL leave err_o=1 (set wins).
REQ-026 wb_adr_o, wb_sel_o, wb_dat_o and wb_we_o SHALL stay stable for the entire BUS state.

Reset
REQ-027 rst_i=0 SHALL immediately force IDLE, cyc/stb/we=0, cpu_ready_o=0, err_o=0, cpu_dat_o=0, counter=0, and all other outputs 0, including mid-cycle; any pending posted write is lost.

Verification
REQ-028 Read: adr 0x0000_1006, sel F, ack after 3 cycles with dat 0x12345678 -> wb_adr_o=0x0000_1004, cpu_ready_o 1 cycle after ack, cpu_dat_o=0x12345678.
REQ-029 Posted write, then read: write in cycle 0 -> cpu_ready_o in cycle 1; read requested in cycle 2 stays pending, no new stb until the write is acked, then the read proceeds.
REQ-030 Timeout: TIMEOUT=4, read, no ack -> cyc/stb drop after 4 cycles, cpu_dat_o=0xDEADBEEF, err_o=1 until err_clr_i pulse.
REQ-031 sel=0 request -> no wb_cyc_o, cpu_ready_o 2 cycles after req, cpu_dat_o=0.
REQ-032 rst_i low during BUS with ack pending -> cyc/stb=0 immediately; after release, a new read completes normally.
REQ-033 Ack in the same cycle as timeout expiry -> data returned, err_o stays 0.

Source files
------------

// File: rtl/mem_wb_bridge_if.sv
// Bundles the CPU request port and the Wishbone master port of mem_wb_bridge.
// The master modport is the bridge's view; slave is the CPU plus Wishbone target.
interface mem_wb_bridge_if;
  logic        cpu_req_i;
  logic        cpu_we_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_adr_i;
  logic [31:0] cpu_dat_i;
  logic [31:0] cpu_dat_o;
  logic        cpu_ready_o;

  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  logic        err_clr_i;
  logic        err_o;

  modport master (
    input  cpu_req_i, cpu_we_i, cpu_sel_i, cpu_adr_i, cpu_dat_i,
    output cpu_dat_o, cpu_ready_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i,
    input  err_clr_i,
    output err_o
  );

  modport slave (
    output cpu_req_i, cpu_we_i, cpu_sel_i, cpu_adr_i, cpu_dat_i,
    input  cpu_dat_o, cpu_ready_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
    output wb_dat_i, wb_ack_i,
    output err_clr_i,
    input  err_o
  );
endinterface

// File: rtl/mem_wb_bridge.sv
// Bridges a simple CPU request port onto a Wishbone master: writes are posted,
// reads wait for the ack, and a bus cycle without ack is aborted after TIMEOUT clocks.
module mem_wb_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic             clk_i,
  input logic             rst_i,
  mem_wb_bridge_if.master bus
);
  localparam int unsigned      CNT_W      = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [31:0]      ABORT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             cyc_q, cyc_d;
  logic             we_q, we_d;
  logic [3:0]       sel_q, sel_d;
  logic [31:0]      adr_q, adr_d;
  logic [31:0]      wdat_q, wdat_d;
  logic [31:0]      rdat_q, rdat_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // The bus abort is OR-ed in after the clear term so a coincident timeout keeps err set.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    ready_d = 1'b0;
    err_d   = err_q & ~bus.err_clr_i;
    cnt_inc = cnt_q + CNT_ONE;

    unique case (state_q)
      IDLE: begin
        if (bus.cpu_req_i) begin
          if (bus.cpu_sel_i != 4'b0000) begin
            adr_d   = bus.cpu_adr_i & 32'hFFFF_FFFC;
            sel_d   = bus.cpu_sel_i;
            wdat_d  = bus.cpu_dat_i;
            we_d    = bus.cpu_we_i;
            cyc_d   = 1'b1;
            cnt_d   = '0;
            ready_d = bus.cpu_we_i;
            state_d = BUS;
          end else begin
            rdat_d  = '0;
            state_d = RESP;
          end
        end
      end

      BUS: begin
        if (bus.wb_ack_i) begin
          cyc_d = 1'b0;
          if (we_q) begin
            state_d = IDLE;
          end else begin
            rdat_d  = bus.wb_dat_i;
            ready_d = 1'b1;
            state_d = RESP;
          end
        end else if (cnt_inc == CNT_LIMIT) begin
          cyc_d = 1'b0;
          err_d = 1'b1;
          if (we_q) begin
            state_d = IDLE;
          end else begin
            rdat_d  = ABORT_DATA;
            ready_d = 1'b1;
            state_d = RESP;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      // Reads arrive with the pulse already raised; a sel=0 request raises it here.
      RESP: begin
        if (ready_q) begin
          state_d = IDLE;
        end else begin
          ready_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.wb_cyc_o    = cyc_q;
  assign bus.wb_stb_o    = cyc_q;
  assign bus.wb_we_o     = we_q;
  assign bus.wb_sel_o    = sel_q;
  assign bus.wb_adr_o    = adr_q;
  assign bus.wb_dat_o    = wdat_q;
  assign bus.cpu_dat_o   = rdat_q;
  assign bus.cpu_ready_o = ready_q;
  assign bus.err_o       = err_q;
endmodule

// File: tb/tb_mem_wb_bridge.sv
// Directed and randomized checks of mem_wb_bridge against a transaction-level model
// that predicts bus cycles, completion cycles, returned data and the error flag.
module tb_mem_wb_bridge;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exp_err;
  int unsigned passed = 0;
  int unsigned total  = 0;

  mem_wb_bridge_if bus_if ();

  mem_wb_bridge #(.TIMEOUT(TO)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus_if.master)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus_if.cpu_req_i = 1'b0;
    bus_if.cpu_we_i  = 1'b0;
    bus_if.cpu_sel_i = 4'h0;
    bus_if.cpu_adr_i = 32'h0;
    bus_if.cpu_dat_i = 32'h0;
    bus_if.wb_dat_i  = 32'h0;
    bus_if.wb_ack_i  = 1'b0;
    bus_if.err_clr_i = 1'b0;
  endtask

  // Request already asserted in the current cycle (cycle 0); ack comes ack_wait cycles after stb.
  task automatic read_body(input logic [31:0] adr, input logic [3:0] sel, input int ack_wait,
                           input logic [31:0] data, input bit clr_at_expiry);
    int          last_bus;
    bit          timed_out;
    logic [31:0] exp_dat;
    tick();
    if (sel == 4'h0) begin
      check_output("sel0_no_cyc_c1", bus_if.wb_cyc_o, 0);
      check_output("sel0_ready_c1", bus_if.cpu_ready_o, 0);
      tick();
      check_output("sel0_no_cyc_c2", bus_if.wb_cyc_o, 0);
      check_output("sel0_ready_c2", bus_if.cpu_ready_o, 1);
      check_output("sel0_dat", bus_if.cpu_dat_o, 0);
      tick();
      bus_if.cpu_req_i = 1'b0;
      check_output("sel0_ready_once", bus_if.cpu_ready_o, 0);
      return;
    end
    timed_out = (ack_wait >= int'(TO));
    last_bus  = timed_out ? int'(TO) : ack_wait + 1;
    for (int c = 1; c <= last_bus; c++) begin
      check_output("rd_cyc", bus_if.wb_cyc_o, 1);
      check_output("rd_stb", bus_if.wb_stb_o, 1);
      check_output("rd_we", bus_if.wb_we_o, 0);
      check_output("rd_adr", bus_if.wb_adr_o, adr & 32'hFFFF_FFFC);
      check_output("rd_sel", bus_if.wb_sel_o, sel);
      check_output("rd_ready_wait", bus_if.cpu_ready_o, 0);
      check_output("rd_err_hold", bus_if.err_o, exp_err);
      if (c == ack_wait + 1) begin
        bus_if.wb_ack_i = 1'b1;
        bus_if.wb_dat_i = data;
      end
      if (timed_out && clr_at_expiry && c == last_bus) bus_if.err_clr_i = 1'b1;
      tick();
      bus_if.wb_ack_i  = 1'b0;
      bus_if.wb_dat_i  = $urandom;
      bus_if.err_clr_i = 1'b0;
    end
    if (timed_out) exp_err = 1'b1;
    exp_dat = timed_out ? 32'hDEADBEEF : data;
    check_output("rd_cyc_drop", bus_if.wb_cyc_o, 0);
    check_output("rd_stb_drop", bus_if.wb_stb_o, 0);
    check_output("rd_ready", bus_if.cpu_ready_o, 1);
    check_output("rd_dat", bus_if.cpu_dat_o, exp_dat);
    check_output("rd_err", bus_if.err_o, exp_err);
    tick();
    bus_if.cpu_req_i = 1'b0;
    check_output("rd_ready_once", bus_if.cpu_ready_o, 0);
    check_output("rd_idle_cyc", bus_if.wb_cyc_o, 0);
  endtask

  task automatic read_txn(input logic [31:0] adr, input logic [3:0] sel, input int ack_wait,
                          input logic [31:0] data, input bit clr_at_expiry);
    bus_if.cpu_req_i = 1'b1;
    bus_if.cpu_we_i  = 1'b0;
    bus_if.cpu_sel_i = sel;
    bus_if.cpu_adr_i = adr;
    bus_if.cpu_dat_i = $urandom;
    read_body(adr, sel, ack_wait, data, clr_at_expiry);
  endtask

  // Posted write; optionally a read is requested in cycle 2 and must wait for the drain.
  task automatic write_txn(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] data,
                           input int ack_wait, input bit pend_read, input logic [31:0] rd_adr,
                           input logic [3:0] rd_sel, input int rd_wait, input logic [31:0] rd_data);
    int last_bus;
    bit timed_out;
    bus_if.cpu_req_i = 1'b1;
    bus_if.cpu_we_i  = 1'b1;
    bus_if.cpu_sel_i = sel;
    bus_if.cpu_adr_i = adr;
    bus_if.cpu_dat_i = data;
    tick();
    timed_out = (ack_wait >= int'(TO));
    last_bus  = timed_out ? int'(TO) : ack_wait + 1;
    for (int c = 1; c <= last_bus; c++) begin
      check_output("wr_cyc", bus_if.wb_cyc_o, 1);
      check_output("wr_we", bus_if.wb_we_o, 1);
      check_output("wr_adr", bus_if.wb_adr_o, adr & 32'hFFFF_FFFC);
      check_output("wr_dat", bus_if.wb_dat_o, data);
      check_output("wr_sel", bus_if.wb_sel_o, sel);
      check_output("wr_ready", bus_if.cpu_ready_o, (c == 1) ? 1 : 0);
      if (c == ack_wait + 1) bus_if.wb_ack_i = 1'b1;
      tick();
      bus_if.wb_ack_i = 1'b0;
      if (c == 1) begin
        bus_if.cpu_dat_i = $urandom;
        if (pend_read) begin
          bus_if.cpu_we_i  = 1'b0;
          bus_if.cpu_sel_i = rd_sel;
          bus_if.cpu_adr_i = rd_adr;
        end else begin
          bus_if.cpu_req_i = 1'b0;
          bus_if.cpu_sel_i = 4'($urandom);
          bus_if.cpu_adr_i = $urandom;
        end
      end
    end
    if (timed_out) exp_err = 1'b1;
    check_output("wr_drained", bus_if.wb_cyc_o, 0);
    check_output("wr_no_ready", bus_if.cpu_ready_o, 0);
    check_output("wr_err", bus_if.err_o, exp_err);
    if (pend_read) read_body(rd_adr, rd_sel, rd_wait, rd_data, 1'b0);
  endtask

  task automatic clear_err();
    bus_if.err_clr_i = 1'b1;
    tick();
    bus_if.err_clr_i = 1'b0;
    exp_err = 1'b0;
    check_output("err_cleared", bus_if.err_o, 0);
  endtask

  initial begin
    idle_inputs();
    exp_err = 1'b0;
    rst_n   = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_output("rst_cyc", bus_if.wb_cyc_o, 0);
    check_output("rst_stb", bus_if.wb_stb_o, 0);
    check_output("rst_we", bus_if.wb_we_o, 0);
    check_output("rst_ready", bus_if.cpu_ready_o, 0);
    check_output("rst_err", bus_if.err_o, 0);
    check_output("rst_dat", bus_if.cpu_dat_o, 0);
    check_output("rst_adr", bus_if.wb_adr_o, 0);
    rst_n = 1'b1;
    tick();

    read_txn(32'h0000_1006, 4'hF, 2, 32'h1234_5678, 1'b0);
    check_output("aligned_adr", bus_if.wb_adr_o, 32'h0000_1004);

    write_txn(32'h0000_0040, 4'hF, 32'hA5A5_5A5A, 3, 1'b1, 32'h0000_0081, 4'h3, 1, 32'hCAFE_F00D);
    read_txn(32'h0000_2000, 4'h0, 0, 32'h0, 1'b0);

    read_txn(32'h0000_3000, 4'hF, 9, 32'h0, 1'b0);
    tick();
    check_output("err_sticky", bus_if.err_o, 1);
    clear_err();
    read_txn(32'h0000_3004, 4'h1, 9, 32'h0, 1'b0);
    read_txn(32'h0000_3008, 4'h2, 9, 32'h0, 1'b1);
    check_output("err_set_wins", bus_if.err_o, 1);
    clear_err();
    read_txn(32'h0000_4000, 4'hF, int'(TO) - 1, 32'h0BAD_CAFE, 1'b0);
    check_output("ack_at_expiry_no_err", bus_if.err_o, 0);
    write_txn(32'h0000_5000, 4'hC, 32'h1111_2222, 7, 1'b0, 32'h0, 4'h0, 0, 32'h0);

    bus_if.cpu_req_i = 1'b1;
    bus_if.cpu_we_i  = 1'b0;
    bus_if.cpu_sel_i = 4'hF;
    bus_if.cpu_adr_i = 32'h0000_6000;
    tick();
    tick();
    check_output("pre_rst_cyc", bus_if.wb_cyc_o, 1);
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_cyc", bus_if.wb_cyc_o, 0);
    check_output("mid_rst_stb", bus_if.wb_stb_o, 0);
    check_output("mid_rst_err", bus_if.err_o, 0);
    check_output("mid_rst_ready", bus_if.cpu_ready_o, 0);
    check_output("mid_rst_dat", bus_if.cpu_dat_o, 0);
    idle_inputs();
    exp_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    read_txn(32'h0000_7002, 4'hF, 0, 32'h7777_8888, 1'b0);

    for (int i = 0; i < 24; i++) begin
      int          kind;
      int          wait_n;
      logic [3:0]  sel;
      logic [31:0] adr;
      logic [31:0] data;
      kind   = int'($urandom_range(0, 3));
      wait_n = int'($urandom_range(0, 5));
      adr    = $urandom;
      data   = $urandom;
      sel    = 4'($urandom);
      if (sel == 4'h0) sel = 4'h8;
      case (kind)
        0:       read_txn(adr, sel, wait_n, data, 1'b0);
        1:       write_txn(adr, sel, data, wait_n, 1'b0, 32'h0, 4'h0, 0, 32'h0);
        2:       read_txn(adr, 4'h0, 0, 32'h0, 1'b0);
        default: write_txn(adr, sel, data, wait_n, 1'b1, $urandom, sel, int'($urandom_range(0, 5)), $urandom);
      endcase
      if ($urandom_range(0, 3) == 0) clear_err();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
